// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// master = issue/consumer side, slave = the logic unit itself.
interface logic_unit_pipe_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int SHF_ROT_WIDTH   = $clog2(DATA_WIDTH),
    parameter int FUNC_CODE_WIDTH = 7
);
    logic                       in_valid;
    logic                       in_ready;
    logic [FUNC_CODE_WIDTH-1:0] lu_func_code;
    logic                       lane_mode;
    logic [DATA_WIDTH-1:0]      data_in_a;
    logic [DATA_WIDTH-1:0]      data_in_b;
    logic [SHF_ROT_WIDTH-1:0]   shift_amt;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      data_out;
    logic                       out_err;
    logic                       busy;

    modport master (
        output in_valid, lu_func_code, lane_mode, data_in_a, data_in_b,
               shift_amt, out_ready,
        input  in_ready, out_valid, data_out, out_err, busy
    );

    modport slave (
        input  in_valid, lu_func_code, lane_mode, data_in_a, data_in_b,
               shift_amt, out_ready,
        output in_ready, out_valid, data_out, out_err, busy
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic/shift/rotate unit with full-word and packed-lane
// modes. S1 holds the accepted operands, S2 holds the registered result.
module logic_unit_pipe #(
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_LANES       = 4,
    parameter int SHF_ROT_WIDTH   = $clog2(DATA_WIDTH),
    parameter int FUNC_CODE_WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    logic_unit_pipe_if.slave  bus
);
    localparam int LANE_WIDTH = DATA_WIDTH / NUM_LANES;
    localparam int LANE_SHW   = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;

    // Opcode encodings (logic_ops.svh set, extended with NOR..ROR)
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_OR   = FUNC_CODE_WIDTH'(0);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_AND  = FUNC_CODE_WIDTH'(1);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_XOR  = FUNC_CODE_WIDTH'(2);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_LRS  = FUNC_CODE_WIDTH'(3);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_ARS  = FUNC_CODE_WIDTH'(4);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_LLS  = FUNC_CODE_WIDTH'(5);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_NOR  = FUNC_CODE_WIDTH'(6);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_NAND = FUNC_CODE_WIDTH'(7);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_XNOR = FUNC_CODE_WIDTH'(8);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_ANDN = FUNC_CODE_WIDTH'(9);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_ROL  = FUNC_CODE_WIDTH'(10);
    localparam logic [FUNC_CODE_WIDTH-1:0] OP_ROR  = FUNC_CODE_WIDTH'(11);

    // Stage S1 state
    logic                       s1_valid_reg;
    logic [FUNC_CODE_WIDTH-1:0] s1_func_reg;
    logic                       s1_lane_reg;
    logic [DATA_WIDTH-1:0]      s1_a_reg;
    logic [DATA_WIDTH-1:0]      s1_b_reg;
    logic [SHF_ROT_WIDTH-1:0]   s1_amt_reg;

    // Stage S2 state (drives the outputs directly)
    logic                       out_valid_reg;
    logic [DATA_WIDTH-1:0]      data_out_reg;
    logic                       out_err_reg;

    logic                       s2_en;
    logic                       in_ready;
    logic                       accept;
    logic [DATA_WIDTH-1:0]      result_next;
    logic                       err_next;

    // Full-word shift/rotate results
    logic [DATA_WIDTH-1:0]      full_lrs, full_ars, full_lls, full_rol, full_ror;
    // Lane-mode shift/rotate results, lanes packed in place
    logic [DATA_WIDTH-1:0]      lane_lrs, lane_ars, lane_lls, lane_rol, lane_ror;

    // S2 can load whenever it is empty or its current beat leaves this cycle
    assign s2_en    = !out_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_en;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.data_out  = data_out_reg;
    assign bus.out_err   = out_err_reg;
    assign bus.busy      = s1_valid_reg || out_valid_reg;

    // Full-word shifts; a right shift by DATA_WIDTH yields 0, so rotate by 0 returns A
    assign full_lrs = s1_a_reg >> s1_amt_reg;
    assign full_ars = $signed(s1_a_reg) >>> s1_amt_reg;
    assign full_lls = s1_a_reg << s1_amt_reg;
    assign full_rol = (s1_a_reg << s1_amt_reg) | (s1_a_reg >> (DATA_WIDTH - int'(s1_amt_reg)));
    assign full_ror = (s1_a_reg >> s1_amt_reg) | (s1_a_reg << (DATA_WIDTH - int'(s1_amt_reg)));

    // Independent per-lane shifters; distance is shift_amt modulo LANE_WIDTH
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_WIDTH-1:0] la;
            logic [LANE_SHW-1:0]   lamt;
            assign la   = s1_a_reg[gi*LANE_WIDTH +: LANE_WIDTH];
            assign lamt = s1_amt_reg[LANE_SHW-1:0];
            assign lane_lrs[gi*LANE_WIDTH +: LANE_WIDTH] = la >> lamt;
            assign lane_ars[gi*LANE_WIDTH +: LANE_WIDTH] = $signed(la) >>> lamt;
            assign lane_lls[gi*LANE_WIDTH +: LANE_WIDTH] = la << lamt;
            assign lane_rol[gi*LANE_WIDTH +: LANE_WIDTH] =
                (la << lamt) | (la >> (LANE_WIDTH - int'(lamt)));
            assign lane_ror[gi*LANE_WIDTH +: LANE_WIDTH] =
                (la >> lamt) | (la << (LANE_WIDTH - int'(lamt)));
        end
    endgenerate

    // Opcode decode and result select; unknown opcodes give 0 with the error flag
    always_comb begin
        result_next = '0;
        err_next    = 1'b0;
        case (s1_func_reg)
            OP_OR:   result_next = s1_a_reg | s1_b_reg;
            OP_AND:  result_next = s1_a_reg & s1_b_reg;
            OP_XOR:  result_next = s1_a_reg ^ s1_b_reg;
            OP_NOR:  result_next = ~(s1_a_reg | s1_b_reg);
            OP_NAND: result_next = ~(s1_a_reg & s1_b_reg);
            OP_XNOR: result_next = ~(s1_a_reg ^ s1_b_reg);
            OP_ANDN: result_next = s1_a_reg & ~s1_b_reg;
            OP_LRS:  result_next = s1_lane_reg ? lane_lrs : full_lrs;
            OP_ARS:  result_next = s1_lane_reg ? lane_ars : full_ars;
            OP_LLS:  result_next = s1_lane_reg ? lane_lls : full_lls;
            OP_ROL:  result_next = s1_lane_reg ? lane_rol : full_rol;
            OP_ROR:  result_next = s1_lane_reg ? lane_ror : full_ror;
            default: err_next    = 1'b1;
        endcase
    end

    // S1: capture a beat on accept; empties when its beat moves on and nothing replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_func_reg  <= '0;
            s1_lane_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_amt_reg   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (accept) begin
                s1_func_reg <= bus.lu_func_code;
                s1_lane_reg <= bus.lane_mode;
                s1_a_reg    <= bus.data_in_a;
                s1_b_reg    <= bus.data_in_b;
                s1_amt_reg  <= bus.shift_amt;
            end
        end
    end

    // S2: register the computed result; holds stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
            out_err_reg   <= 1'b0;
        end else if (s2_en) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                data_out_reg <= result_next;
                out_err_reg  <= err_next;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe with hand-computed expected values.
module tb_logic_unit_pipe;
    localparam logic [6:0] OP_OR   = 7'd0;
    localparam logic [6:0] OP_AND  = 7'd1;
    localparam logic [6:0] OP_XOR  = 7'd2;
    localparam logic [6:0] OP_LRS  = 7'd3;
    localparam logic [6:0] OP_ARS  = 7'd4;
    localparam logic [6:0] OP_LLS  = 7'd5;
    localparam logic [6:0] OP_NOR  = 7'd6;
    localparam logic [6:0] OP_NAND = 7'd7;
    localparam logic [6:0] OP_XNOR = 7'd8;
    localparam logic [6:0] OP_ANDN = 7'd9;
    localparam logic [6:0] OP_ROL  = 7'd10;
    localparam logic [6:0] OP_ROR  = 7'd11;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    localparam logic [63:0] VA = 64'h00FF_00FF_0000_FFFF;
    localparam logic [63:0] VB = 64'h0F0F_0F0F_F0F0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.DATA_WIDTH(64), .SHF_ROT_WIDTH(6), .FUNC_CODE_WIDTH(7)) bus ();

    logic_unit_pipe #(
        .DATA_WIDTH(64), .NUM_LANES(4), .SHF_ROT_WIDTH(6), .FUNC_CODE_WIDTH(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input logic [6:0] func, input logic lane, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] amt);
        bus.in_valid     = 1'b1;
        bus.lu_func_code = func;
        bus.lane_mode    = lane;
        bus.data_in_a    = a;
        bus.data_in_b    = b;
        bus.shift_amt    = amt;
    endtask

    // One isolated beat with out_ready high: accept, one cycle in S1, then the result
    task automatic run_beat(input string tag, input logic [6:0] func, input logic lane,
                            input logic [63:0] a, input logic [63:0] b, input logic [5:0] amt,
                            input logic [63:0] exp_d, input logic exp_e);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(func, lane, a, b, amt);
        check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val({tag, "_lat"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_val({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_val({tag, "_data"}, bus.data_out, exp_d);
        check_val({tag, "_err"}, 64'(bus.out_err), 64'(exp_e));
    endtask

    logic [63:0] bp_exp [3];
    logic [63:0] tp_exp [3];
    logic [6:0]  tp_op  [3];

    initial begin
        bus.out_ready = 1'b1;
        drive(OP_OR, 1'b0, '1, '1, 6'd0);   // in_valid high during reset

        // Reset: two cycles with in_valid asserted
        @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val("rst_data_out", bus.data_out, 64'd0);
        check_val("rst_out_err", 64'(bus.out_err), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("post_rst_busy", 64'(bus.busy), 64'd0);

        // Full-word shifts and rotates
        run_beat("rol_full", OP_ROL, 1'b0, 64'h8000_0000_0000_0001, '0, 6'd4, 64'h0000_0000_0000_0018, 1'b0);
        run_beat("ror_full", OP_ROR, 1'b0, 64'h0000_0000_0000_0018, '0, 6'd4, 64'h8000_0000_0000_0001, 1'b0);
        run_beat("lrs_full", OP_LRS, 1'b0, 64'h8000_0000_0000_0010, '0, 6'd4, 64'h0800_0000_0000_0001, 1'b0);
        run_beat("ars_full", OP_ARS, 1'b0, 64'h8000_0000_0000_0010, '0, 6'd4, 64'hF800_0000_0000_0001, 1'b0);
        run_beat("lls_max", OP_LLS, 1'b0, 64'h0000_0000_0000_0001, '0, 6'd63, 64'h8000_0000_0000_0000, 1'b0);
        run_beat("lrs_max", OP_LRS, 1'b0, 64'h8000_0000_0000_0000, '0, 6'd63, 64'h0000_0000_0000_0001, 1'b0);
        run_beat("rol_zero", OP_ROL, 1'b0, 64'h1234_5678_9ABC_DEF0, '0, 6'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        run_beat("ror_zero", OP_ROR, 1'b0, 64'h1234_5678_9ABC_DEF0, '0, 6'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);

        // Lane-mode shifts and rotates (16-bit lanes)
        run_beat("ars_lane", OP_ARS, 1'b1, 64'h8000_7FFF_F0F0_0001, '0, 6'd4, 64'hF800_07FF_FF0F_0000, 1'b0);
        run_beat("lrs_lane", OP_LRS, 1'b1, 64'h8000_7FFF_F0F0_0001, '0, 6'd4, 64'h0800_07FF_0F0F_0000, 1'b0);
        run_beat("lls_lane", OP_LLS, 1'b1, 64'h8001_1234_00FF_FFFF, '0, 6'd4, 64'h0010_2340_0FF0_FFF0, 1'b0);
        run_beat("rol_lane_mod", OP_ROL, 1'b1, 64'h8001_1234_00FF_F00F, '0, 6'd20, 64'h0018_2341_0FF0_00FF, 1'b0);
        run_beat("ror_lane", OP_ROR, 1'b1, 64'h0018_2341_0FF0_00FF, '0, 6'd4, 64'h8001_1234_00FF_F00F, 1'b0);

        // Bitwise ops (lane_mode has no effect)
        run_beat("nor", OP_NOR, 1'b0, VA, VB, 6'd0, 64'hF000_F000_0F0F_0000, 1'b0);
        run_beat("nand", OP_NAND, 1'b1, VA, VB, 6'd0, 64'hFFF0_FFF0_FFFF_FFFF, 1'b0);
        run_beat("xnor", OP_XNOR, 1'b0, VA, VB, 6'd0, 64'hF00F_F00F_0F0F_0000, 1'b0);

        // Throughput: OR, AND, XOR back-to-back with out_ready high
        tp_op[0] = OP_OR;  tp_exp[0] = 64'h0FFF_0FFF_F0F0_FFFF;
        tp_op[1] = OP_AND; tp_exp[1] = 64'h000F_000F_0000_0000;
        tp_op[2] = OP_XOR; tp_exp[2] = 64'h0FF0_0FF0_F0F0_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check_val($sformatf("tp%0d_valid", i - 2), 64'(bus.out_valid), 64'd1);
                check_val($sformatf("tp%0d_data", i - 2), bus.data_out, tp_exp[i-2]);
            end
            if (i < 3) begin
                drive(tp_op[i], 1'b1, VA, VB, 6'd0);
                check_val($sformatf("tp%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Back-pressure: XOR, ANDN, ROR with out_ready low
        bp_exp[0] = 64'h0FF0_0FF0_F0F0_FFFF;
        bp_exp[1] = 64'h00F0_00F0_0000_FFFF;
        bp_exp[2] = 64'h1000_0000_0000_0000;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(OP_XOR, 1'b0, VA, VB, 6'd0);
        check_val("bp_acc0", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(OP_ANDN, 1'b0, VA, VB, 6'd0);
        check_val("bp_acc1", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(OP_ROR, 1'b0, 64'h0000_0000_0000_0001, '0, 6'd4);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("bp_stall%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
            check_val($sformatf("bp_stall%0d_hold", i), bus.data_out, bp_exp[0]);
            @(negedge clk);
        end
        check_val("bp_stall3_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_ready_comb", 64'(bus.in_ready), 64'd1);
        check_val("bp_res0", bus.data_out, bp_exp[0]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("bp_res1_valid", 64'(bus.out_valid), 64'd1);
        check_val("bp_res1", bus.data_out, bp_exp[1]);
        @(negedge clk);
        check_val("bp_res2_valid", 64'(bus.out_valid), 64'd1);
        check_val("bp_res2", bus.data_out, bp_exp[2]);
        @(negedge clk);
        check_val("bp_drained_valid", 64'(bus.out_valid), 64'd0);
        check_val("bp_drained_busy", 64'(bus.busy), 64'd0);

        // Unknown opcode, then a legal OR
        run_beat("bad_op", OP_BAD, 1'b0, '1, '1, 6'd0, 64'd0, 1'b1);
        run_beat("or_after_bad", OP_OR, 1'b0, '1, '1, 6'd0, '1, 1'b0);

        // Reset with both stages occupied
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(OP_OR, 1'b0, VA, VB, 6'd0);
        @(negedge clk);
        drive(OP_XOR, 1'b0, VA, VB, 6'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        check_val("mid_pre_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_val("mid_rst_data", bus.data_out, 64'd0);
        run_beat("and_after_rst", OP_AND, 1'b0, VA, VB, 6'd0, 64'h000F_000F_0000_0000, 1'b0);
        @(negedge clk);
        check_val("final_busy", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
